// File: rtl/dcache_arb_pkg.sv
// Shared types for the dcache port arbiter: requester index, FSM state and
// the round-robin pointer advance helper.
package dcache_arb_pkg;

  // Requester count the index type is sized for; the arbiter's NumReq must match.
  localparam int unsigned NumReqCfg = 2;
  localparam int unsigned IdxWidth  = (NumReqCfg > 1) ? $clog2(NumReqCfg) : 1;

  typedef logic [IdxWidth-1:0] idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Next round-robin position after cur, wrapping modulo n.
  function automatic idx_t rr_next(idx_t cur, int unsigned n);
    return ((32'(cur) + 32'd1) >= n) ? '0 : idx_t'(32'(cur) + 32'd1);
  endfunction

endpackage

// File: rtl/dcache_arb_id_fifo.sv
// Synchronous FIFO of requester indices, one entry per issued-but-unanswered
// request, used to route in-order responses back to their owners.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   push_i, data_i   enqueue an index (ignored when full)
//   pop_i            dequeue the head (ignored when empty)
//   data_o           head entry
//   full_o, empty_o  occupancy flags, from registered state only
module dcache_arb_id_fifo
  import dcache_arb_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  idx_t data_i,
  input  logic pop_i,
  output idx_t data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PtrWidth = $clog2(Depth);
  localparam int unsigned CntWidth = PtrWidth + 1;

  idx_t                mem_q [Depth];
  logic [PtrWidth-1:0] wr_q, wr_d;
  logic [PtrWidth-1:0] rd_q, rd_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                do_push;
  logic                do_pop;

  assign full_o  = (cnt_q == CntWidth'(Depth));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_q];

  // Guard against misuse so the pointers and count never diverge.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap naturally because Depth is a power of two.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + PtrWidth'(1);
    if (do_pop)  rd_d = rd_q + PtrWidth'(1);
    cnt_d = cnt_q + CntWidth'(do_push) - CntWidth'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; validity is tracked by the count.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Shares the core's single external dcache request port among NumReq
// requesters. Round-robin arbitration, grant held under backpressure, and
// in-order response routing through an ID FIFO.
// Ports:
//   clk_i, rst_i                     clock, synchronous active-high reset
//   slv_req_valid/ready/addr/we/wdata/be  per-requester request channel
//   slv_rsp_valid, slv_rsp_rdata     response strobe to owner, broadcast data
//   mst_req_valid/ready/addr/we/wdata/be  request channel to the dcache
//   mst_rsp_valid, mst_rsp_rdata     in-order responses from the dcache
//   err_o                            sticky: response with nothing outstanding
module dcache_port_arbiter
  import dcache_arb_pkg::*;
#(
  parameter  int unsigned NumReq    = NumReqCfg,
  parameter  int unsigned AddrWidth = 64,
  parameter  int unsigned DataWidth = 64,
  parameter  int unsigned MaxOutst  = 4,
  localparam int unsigned BeWidth   = DataWidth / 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NumReq-1:0]           slv_req_valid,
  output logic [NumReq-1:0]           slv_req_ready,
  input  logic [NumReq*AddrWidth-1:0] slv_req_addr,
  input  logic [NumReq-1:0]           slv_req_we,
  input  logic [NumReq*DataWidth-1:0] slv_req_wdata,
  input  logic [NumReq*BeWidth-1:0]   slv_req_be,
  output logic [NumReq-1:0]           slv_rsp_valid,
  output logic [DataWidth-1:0]        slv_rsp_rdata,
  output logic                        mst_req_valid,
  input  logic                        mst_req_ready,
  output logic [AddrWidth-1:0]        mst_req_addr,
  output logic                        mst_req_we,
  output logic [DataWidth-1:0]        mst_req_wdata,
  output logic [BeWidth-1:0]          mst_req_be,
  input  logic                        mst_rsp_valid,
  input  logic [DataWidth-1:0]        mst_rsp_rdata,
  output logic                        err_o
);

  state_e state_q, state_d;
  idx_t   rr_q, rr_d;
  idx_t   hold_q, hold_d;
  logic   err_q, err_d;

  idx_t   win;
  idx_t   cand;
  logic   found;
  idx_t   sel;
  logic   req_valid;
  logic   grant;
  logic   rsp_hit;
  idx_t   fifo_head;
  logic   fifo_full;
  logic   fifo_empty;

  // Per-requester payload views.
  logic [AddrWidth-1:0] addr_arr  [NumReq];
  logic [DataWidth-1:0] wdata_arr [NumReq];
  logic [BeWidth-1:0]   be_arr    [NumReq];

  for (genvar g = 0; g < NumReq; g++) begin : g_unpack
    assign addr_arr[g]  = slv_req_addr[g*AddrWidth +: AddrWidth];
    assign wdata_arr[g] = slv_req_wdata[g*DataWidth +: DataWidth];
    assign be_arr[g]    = slv_req_be[g*BeWidth +: BeWidth];
  end

  // Winner: first valid requester at or after the round-robin pointer.
  always_comb begin
    win   = rr_q;
    cand  = rr_q;
    found = 1'b0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = idx_t'((32'(rr_q) + i) % NumReq);
      if (!found && slv_req_valid[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  // Next-state, grant and response routing; everything idles during reset.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    hold_d    = hold_q;
    err_d     = err_q;
    sel       = rr_q;
    req_valid = 1'b0;
    grant     = 1'b0;
    rsp_hit   = 1'b0;
    if (!rst_i) begin
      case (state_q)
        IDLE: begin
          if (!fifo_full && found) begin
            sel       = win;
            req_valid = 1'b1;
            if (mst_req_ready) begin
              grant = 1'b1;
            end else begin
              hold_d  = win;
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          sel       = hold_q;
          req_valid = 1'b1;
          if (mst_req_ready) begin
            grant   = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
      if (grant) rr_d = rr_next(sel, NumReq);
      rsp_hit = mst_rsp_valid && !fifo_empty;
      if (mst_rsp_valid && fifo_empty) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_q    <= '0;
      hold_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
    end
  end

  dcache_arb_id_fifo #(
    .Depth (MaxOutst)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (grant),
    .data_i  (sel),
    .pop_i   (rsp_hit),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Zero-latency pass-through of the selected requester; payload zeroed when idle.
  assign mst_req_valid = req_valid;
  assign mst_req_addr  = req_valid ? addr_arr[sel]      : '0;
  assign mst_req_we    = req_valid ? slv_req_we[sel]    : 1'b0;
  assign mst_req_wdata = req_valid ? wdata_arr[sel]     : '0;
  assign mst_req_be    = req_valid ? be_arr[sel]        : '0;
  assign slv_req_ready = grant   ? (NumReq'(1) << sel)       : '0;
  assign slv_rsp_valid = rsp_hit ? (NumReq'(1) << fifo_head) : '0;
  assign slv_rsp_rdata = mst_rsp_rdata;
  assign err_o         = err_q && !rst_i;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Bench for dcache_port_arbiter: a directed vector table followed by
// randomized traffic checked against a queue-based reference model.
module tb_dcache_port_arbiter;

  localparam int unsigned NReq   = 2;
  localparam int unsigned AW     = 64;
  localparam int unsigned DW     = 64;
  localparam int unsigned BW     = DW / 8;
  localparam int unsigned Outst  = 4;
  localparam int unsigned NRand  = 3000;

  logic              clk = 1'b0;
  logic              rst_i;
  logic [NReq-1:0]   slv_req_valid;
  logic [NReq-1:0]   slv_req_ready;
  logic [NReq*AW-1:0] slv_req_addr;
  logic [NReq-1:0]   slv_req_we;
  logic [NReq*DW-1:0] slv_req_wdata;
  logic [NReq*BW-1:0] slv_req_be;
  logic [NReq-1:0]   slv_rsp_valid;
  logic [DW-1:0]     slv_rsp_rdata;
  logic              mst_req_valid;
  logic              mst_req_ready;
  logic [AW-1:0]     mst_req_addr;
  logic              mst_req_we;
  logic [DW-1:0]     mst_req_wdata;
  logic [BW-1:0]     mst_req_be;
  logic              mst_rsp_valid;
  logic [DW-1:0]     mst_rsp_rdata;
  logic              err_o;

  always #5 clk = ~clk;

  dcache_port_arbiter #(
    .NumReq    (NReq),
    .AddrWidth (AW),
    .DataWidth (DW),
    .MaxOutst  (Outst)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .slv_req_valid (slv_req_valid),
    .slv_req_ready (slv_req_ready),
    .slv_req_addr  (slv_req_addr),
    .slv_req_we    (slv_req_we),
    .slv_req_wdata (slv_req_wdata),
    .slv_req_be    (slv_req_be),
    .slv_rsp_valid (slv_rsp_valid),
    .slv_rsp_rdata (slv_rsp_rdata),
    .mst_req_valid (mst_req_valid),
    .mst_req_ready (mst_req_ready),
    .mst_req_addr  (mst_req_addr),
    .mst_req_we    (mst_req_we),
    .mst_req_wdata (mst_req_wdata),
    .mst_req_be    (mst_req_be),
    .mst_rsp_valid (mst_rsp_valid),
    .mst_rsp_rdata (mst_rsp_rdata),
    .err_o         (err_o)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  vld;
    logic        rdy;
    logic        rspv;
    logic [63:0] rdata;
    logic        ev;     // expected mst_req_valid
    logic [1:0]  ereq;   // expected slv_req_ready
    int          esel;   // requester whose payload must appear when ev
    logic [1:0]  ersp;   // expected slv_rsp_valid
    logic        eerr;   // expected err_o during this cycle
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Requester payloads currently presented.
  logic [AW-1:0] p_addr  [NReq];
  logic          p_we    [NReq];
  logic [DW-1:0] p_wdata [NReq];
  logic [BW-1:0] p_be    [NReq];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, compare outputs mid-cycle, advance past the edge.
  task automatic run_cycle(input string tag, input vec_t v);
    rst_i         = v.rst;
    slv_req_valid = v.vld;
    mst_req_ready = v.rdy;
    mst_rsp_valid = v.rspv;
    mst_rsp_rdata = v.rdata;
    slv_req_addr  = {p_addr[1], p_addr[0]};
    slv_req_we    = {p_we[1], p_we[0]};
    slv_req_wdata = {p_wdata[1], p_wdata[0]};
    slv_req_be    = {p_be[1], p_be[0]};
    #2;
    chk({tag, " mst_req_valid"}, 64'(mst_req_valid), 64'(v.ev));
    chk({tag, " slv_req_ready"}, 64'(slv_req_ready), 64'(v.ereq));
    chk({tag, " slv_rsp_valid"}, 64'(slv_rsp_valid), 64'(v.ersp));
    chk({tag, " slv_rsp_rdata"}, slv_rsp_rdata, v.rdata);
    chk({tag, " err_o"}, 64'(err_o), 64'(v.eerr));
    if (v.ev) begin
      chk({tag, " mst_req_addr"}, mst_req_addr, p_addr[v.esel]);
      chk({tag, " mst_req_we"}, 64'(mst_req_we), 64'(p_we[v.esel]));
      chk({tag, " mst_req_wdata"}, mst_req_wdata, p_wdata[v.esel]);
      chk({tag, " mst_req_be"}, 64'(mst_req_be), 64'(p_be[v.esel]));
    end
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic r, input logic [1:0] vl, input logic rd,
                              input logic rv, input logic [63:0] rdat, input logic e_v,
                              input logic [1:0] e_rq, input int e_s, input logic [1:0] e_rs,
                              input logic e_er);
    vec_t v;
    v.rst = r; v.vld = vl; v.rdy = rd; v.rspv = rv; v.rdata = rdat;
    v.ev = e_v; v.ereq = e_rq; v.esel = e_s; v.ersp = e_rs; v.eerr = e_er;
    return v;
  endfunction

  // Reference model state.
  int   m_rr;
  int   m_hold;      // requester being held under backpressure, -1 if none
  int   m_q[$];      // owners of outstanding requests, oldest first
  logic m_err;
  logic pend [NReq];

  initial begin
    vec_t tbl[$];
    vec_t v;

    p_addr[0]  = 64'h0000_1000_0000_0A00; p_addr[1]  = 64'h0000_2000_0000_0B08;
    p_we[0]    = 1'b0;                    p_we[1]    = 1'b1;
    p_wdata[0] = 64'h1111_2222_3333_4444; p_wdata[1] = 64'h5555_6666_7777_8888;
    p_be[0]    = 8'hFF;                   p_be[1]    = 8'h0F;

    rst_i = 1'b1; slv_req_valid = '0; mst_req_ready = 1'b0;
    mst_rsp_valid = 1'b0; mst_rsp_rdata = '0;
    slv_req_addr = '0; slv_req_we = '0; slv_req_wdata = '0; slv_req_be = '0;
    repeat (2) @(posedge clk);
    #1;

    //                 rst vld   rdy  rspv rdata        ev  ereq  sel ersp  err
    tbl.push_back(mk(1, 2'b00, 0, 0, 64'h0,      0, 2'b00, 0, 2'b00, 0)); // reset state
    tbl.push_back(mk(0, 2'b01, 1, 0, 64'h0,      1, 2'b01, 0, 2'b00, 0)); // single req0
    tbl.push_back(mk(0, 2'b00, 0, 1, 64'hDEAD,   0, 2'b00, 0, 2'b01, 0)); // its response
    tbl.push_back(mk(0, 2'b11, 1, 0, 64'h0,      1, 2'b10, 1, 2'b00, 0)); // alternate
    tbl.push_back(mk(0, 2'b11, 1, 0, 64'h0,      1, 2'b01, 0, 2'b00, 0));
    tbl.push_back(mk(0, 2'b11, 1, 1, 64'hA1,     1, 2'b10, 1, 2'b10, 0)); // push+pop
    tbl.push_back(mk(0, 2'b11, 1, 1, 64'hA2,     1, 2'b01, 0, 2'b01, 0));
    tbl.push_back(mk(0, 2'b00, 0, 1, 64'hA3,     0, 2'b00, 0, 2'b10, 0));
    tbl.push_back(mk(0, 2'b00, 0, 1, 64'hA4,     0, 2'b00, 0, 2'b01, 0));
    tbl.push_back(mk(0, 2'b10, 1, 0, 64'h0,      1, 2'b10, 1, 2'b00, 0)); // rr -> 0
    tbl.push_back(mk(0, 2'b00, 0, 1, 64'hB0,     0, 2'b00, 0, 2'b10, 0));
    tbl.push_back(mk(0, 2'b10, 0, 0, 64'h0,      1, 2'b00, 1, 2'b00, 0)); // hold req1
    tbl.push_back(mk(0, 2'b11, 0, 0, 64'h0,      1, 2'b00, 1, 2'b00, 0)); // req0 rises
    tbl.push_back(mk(0, 2'b11, 0, 0, 64'h0,      1, 2'b00, 1, 2'b00, 0));
    tbl.push_back(mk(0, 2'b11, 1, 0, 64'h0,      1, 2'b10, 1, 2'b00, 0)); // req1 granted
    tbl.push_back(mk(0, 2'b01, 1, 0, 64'h0,      1, 2'b01, 0, 2'b00, 0)); // req0 next
    tbl.push_back(mk(0, 2'b00, 0, 1, 64'hC1,     0, 2'b00, 0, 2'b10, 0));
    tbl.push_back(mk(0, 2'b00, 0, 1, 64'hC2,     0, 2'b00, 0, 2'b01, 0));
    tbl.push_back(mk(0, 2'b11, 1, 0, 64'h0,      1, 2'b10, 1, 2'b00, 0)); // fill FIFO
    tbl.push_back(mk(0, 2'b11, 1, 0, 64'h0,      1, 2'b01, 0, 2'b00, 0));
    tbl.push_back(mk(0, 2'b11, 1, 0, 64'h0,      1, 2'b10, 1, 2'b00, 0));
    tbl.push_back(mk(0, 2'b11, 1, 0, 64'h0,      1, 2'b01, 0, 2'b00, 0));
    tbl.push_back(mk(0, 2'b11, 1, 0, 64'h0,      0, 2'b00, 0, 2'b00, 0)); // full
    tbl.push_back(mk(0, 2'b11, 1, 1, 64'hD1,     0, 2'b00, 0, 2'b10, 0)); // pop, no push
    tbl.push_back(mk(0, 2'b11, 1, 0, 64'h0,      1, 2'b10, 1, 2'b00, 0)); // 5th accepted
    tbl.push_back(mk(0, 2'b00, 0, 1, 64'hD2,     0, 2'b00, 0, 2'b01, 0));
    tbl.push_back(mk(0, 2'b00, 0, 1, 64'hD3,     0, 2'b00, 0, 2'b10, 0));
    tbl.push_back(mk(0, 2'b00, 0, 1, 64'hD4,     0, 2'b00, 0, 2'b01, 0));
    tbl.push_back(mk(0, 2'b00, 0, 1, 64'hD5,     0, 2'b00, 0, 2'b10, 0));
    tbl.push_back(mk(0, 2'b00, 0, 1, 64'hE0,     0, 2'b00, 0, 2'b00, 0)); // spurious
    tbl.push_back(mk(0, 2'b00, 0, 0, 64'h0,      0, 2'b00, 0, 2'b00, 1)); // sticky
    tbl.push_back(mk(0, 2'b01, 1, 1, 64'hE1,     1, 2'b01, 0, 2'b00, 1)); // empty push+rsp
    tbl.push_back(mk(0, 2'b11, 1, 0, 64'h0,      1, 2'b10, 1, 2'b00, 1));
    tbl.push_back(mk(0, 2'b11, 1, 0, 64'h0,      1, 2'b01, 0, 2'b00, 1)); // 3 outstanding
    tbl.push_back(mk(0, 2'b10, 0, 0, 64'h0,      1, 2'b00, 1, 2'b00, 1)); // HOLD on req1
    tbl.push_back(mk(1, 2'b10, 0, 0, 64'h0,      0, 2'b00, 0, 2'b00, 0)); // reset mid-op
    tbl.push_back(mk(0, 2'b11, 0, 0, 64'h0,      1, 2'b00, 0, 2'b00, 0)); // rr back to 0
    tbl.push_back(mk(0, 2'b11, 1, 1, 64'hF1,     1, 2'b01, 0, 2'b00, 0)); // late rsp
    tbl.push_back(mk(0, 2'b00, 0, 1, 64'hF2,     0, 2'b00, 0, 2'b01, 1));

    foreach (tbl[i]) run_cycle($sformatf("row%0d", i), tbl[i]);

    // Randomized traffic against the reference model; first cycle is a reset.
    m_rr = 0; m_hold = -1; m_q.delete(); m_err = 1'b0;
    for (int r = 0; r < NReq; r++) pend[r] = 1'b0;
    for (int cyc = 0; cyc < NRand; cyc++) begin
      int  sel;
      logic any_ev;
      v.rst = (cyc == 0) || ($urandom_range(0, 299) == 0);
      for (int r = 0; r < NReq; r++) begin
        if (!pend[r] && $urandom_range(0, 2) == 0) begin
          pend[r]    = 1'b1;
          p_addr[r]  = {$urandom, $urandom};
          p_we[r]    = 1'($urandom_range(0, 1));
          p_wdata[r] = {$urandom, $urandom};
          p_be[r]    = 8'($urandom);
        end
      end
      v.vld   = {pend[1], pend[0]};
      v.rdy   = ($urandom_range(0, 3) != 0);
      v.rspv  = (m_q.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 49) == 0);
      v.rdata = {$urandom, $urandom};

      sel    = 0;
      any_ev = 1'b0;
      if (!v.rst) begin
        if (m_hold >= 0) begin
          any_ev = 1'b1;
          sel    = m_hold;
        end else if (m_q.size() < Outst) begin
          for (int k = 0; k < NReq; k++) begin
            int r;
            r = (m_rr + k) % NReq;
            if (!any_ev && pend[r]) begin
              any_ev = 1'b1;
              sel    = r;
            end
          end
        end
      end
      v.ev   = any_ev;
      v.esel = sel;
      v.ereq = (any_ev && v.rdy) ? 2'(1 << sel) : 2'b00;
      v.ersp = (!v.rst && v.rspv && m_q.size() > 0) ? 2'(1 << m_q[0]) : 2'b00;
      v.eerr = m_err && !v.rst;

      run_cycle($sformatf("rand%0d", cyc), v);

      if (v.rst) begin
        m_rr = 0; m_hold = -1; m_q.delete(); m_err = 1'b0;
      end else begin
        if (v.rspv) begin
          if (m_q.size() > 0) void'(m_q.pop_front());
          else m_err = 1'b1;
        end
        if (any_ev && v.rdy) begin
          m_q.push_back(sel);
          m_rr      = (sel + 1) % NReq;
          pend[sel] = 1'b0;
        end
        m_hold = (any_ev && !v.rdy) ? sel : -1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
